// File: rtl/exc_ctrl.sv
// Exception controller: prioritises MEM-stage exceptions/interrupts, commits one to CP0 and redirects the PC.
// Latency 1 (registered commit); flush held for FLUSH_CYCLES more cycles, during which new events are dropped.
module exc_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] REFILL_OFF   = 32'h0000_0000,
    parameter logic [31:0] GENERAL_OFF  = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [7:0]  exc_flags_i,
    input  logic        tlb_load_i,
    input  logic [31:0] pc_i,
    input  logic        in_delay_slot_i,
    input  logic [31:0] badVaddr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic [31:0] ebase_i,
    output logic [31:0] exceptionType_o,
    output logic        tlbmiss_o,
    output logic        load_o,
    output logic [31:0] exceptionAddr_o,
    output logic [31:0] badVaddr_o,
    output logic        in_delay_slot_o,
    output logic        flush_o,
    output logic [31:0] newPc_o,
    output logic        redirect_o
);
    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [3:0] FLUSH_CNT = 4'(FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] etype_q, etype_d;
    logic        tlbmiss_q, tlbmiss_d;
    logic        load_q, load_d;
    logic [31:0] eaddr_q, eaddr_d;
    logic [31:0] bad_q, bad_d;
    logic        ds_q, ds_d;
    logic        flush_q, flush_d;
    logic [31:0] npc_q, npc_d;
    logic        redirect_q, redirect_d;

    logic int_pend;
    logic accept;
    logic unused_bits;

    assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    always_comb begin
        int_pend   = valid_i & status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
        accept     = (state_q == IDLE) & (int_pend | (valid_i & (|exc_flags_i)));
        state_d    = state_q;
        cnt_d      = cnt_q;
        etype_d    = 32'h0;
        tlbmiss_d  = 1'b0;
        load_d     = 1'b0;
        eaddr_d    = 32'h0;
        bad_d      = 32'h0;
        ds_d       = 1'b0;
        flush_d    = 1'b0;
        npc_d      = 32'h0;
        redirect_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = FLUSH;
                    cnt_d      = FLUSH_CNT;
                    flush_d    = 1'b1;
                    redirect_d = 1'b1;
                    eaddr_d    = pc_i;
                    bad_d      = badVaddr_i;
                    ds_d       = in_delay_slot_i;
                    npc_d      = ebase_i + GENERAL_OFF;
                    // Interrupt beats every flag; the flagged instruction re-executes after eret.
                    if (int_pend) begin
                        etype_d = 32'h1;
                    end else if (exc_flags_i[7]) begin
                        tlbmiss_d = 1'b1;
                        load_d    = tlb_load_i;
                        if (!status_i[1]) npc_d = ebase_i + REFILL_OFF;
                    end else if (exc_flags_i[0]) begin
                        etype_d = 32'h4;
                    end else if (exc_flags_i[4]) begin
                        etype_d = 32'ha;
                    end else if (exc_flags_i[2]) begin
                        etype_d = 32'h8;
                    end else if (exc_flags_i[3]) begin
                        etype_d = 32'h9;
                    end else if (exc_flags_i[5]) begin
                        etype_d = 32'hc;
                    end else if (exc_flags_i[1]) begin
                        etype_d = 32'h5;
                    end else begin
                        etype_d = 32'he;
                        npc_d   = epc_i;
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    flush_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            etype_q    <= 32'h0;
            tlbmiss_q  <= 1'b0;
            load_q     <= 1'b0;
            eaddr_q    <= 32'h0;
            bad_q      <= 32'h0;
            ds_q       <= 1'b0;
            flush_q    <= 1'b0;
            npc_q      <= 32'h0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            etype_q    <= etype_d;
            tlbmiss_q  <= tlbmiss_d;
            load_q     <= load_d;
            eaddr_q    <= eaddr_d;
            bad_q      <= bad_d;
            ds_q       <= ds_d;
            flush_q    <= flush_d;
            npc_q      <= npc_d;
            redirect_q <= redirect_d;
        end
    end

    assign exceptionType_o = etype_q;
    assign tlbmiss_o       = tlbmiss_q;
    assign load_o          = load_q;
    assign exceptionAddr_o = eaddr_q;
    assign badVaddr_o      = bad_q;
    assign in_delay_slot_o = ds_q;
    assign flush_o         = flush_q;
    assign newPc_o         = npc_q;
    assign redirect_o      = redirect_q;
endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed vector table, multi-cycle corner sequences, random run against a reference model.
module tb_exc_ctrl;
    localparam int FC = 2;

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [7:0]  flags;
        logic        tlb_load;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] ebase;
    } in_t;

    typedef struct packed {
        logic [31:0] etype;
        logic        tlbmiss;
        logic        load;
        logic [31:0] eaddr;
        logic [31:0] bad;
        logic        ds;
        logic        flush;
        logic [31:0] npc;
        logic        redirect;
    } out_t;

    typedef struct {
        string name;
        in_t   inp;
        out_t  exp;
    } vec_t;

    // Flag bit order by priority (after interrupt) and the code each one reports.
    localparam int ORD[8]  = '{7, 0, 4, 2, 3, 5, 1, 6};
    localparam int CODE[8] = '{0, 4, 10, 8, 9, 12, 5, 14};

    logic        clk = 1'b0;
    logic        rst, valid_i, tlb_load_i, in_delay_slot_i;
    logic [7:0]  exc_flags_i;
    logic [31:0] pc_i, badVaddr_i, status_i, cause_i, epc_i, ebase_i;
    logic [31:0] exceptionType_o, exceptionAddr_o, badVaddr_o, newPc_o;
    logic        tlbmiss_o, load_o, in_delay_slot_o, flush_o, redirect_o;
    out_t        act;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    exc_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .exc_flags_i(exc_flags_i),
        .tlb_load_i(tlb_load_i), .pc_i(pc_i), .in_delay_slot_i(in_delay_slot_i),
        .badVaddr_i(badVaddr_i), .status_i(status_i), .cause_i(cause_i),
        .epc_i(epc_i), .ebase_i(ebase_i), .exceptionType_o(exceptionType_o),
        .tlbmiss_o(tlbmiss_o), .load_o(load_o), .exceptionAddr_o(exceptionAddr_o),
        .badVaddr_o(badVaddr_o), .in_delay_slot_o(in_delay_slot_o), .flush_o(flush_o),
        .newPc_o(newPc_o), .redirect_o(redirect_o)
    );

    assign act = {exceptionType_o, tlbmiss_o, load_o, exceptionAddr_o, badVaddr_o,
                  in_delay_slot_o, flush_o, newPc_o, redirect_o};

    function automatic in_t mk(logic v, logic [7:0] f, logic tl, logic [31:0] pc, logic ds,
                               logic [31:0] bad, logic [31:0] st, logic [31:0] ca,
                               logic [31:0] epc, logic [31:0] eb);
        in_t x;
        x.rst = 1'b0; x.valid = v; x.flags = f; x.tlb_load = tl; x.pc = pc; x.ds = ds;
        x.bad = bad; x.status = st; x.cause = ca; x.epc = epc; x.ebase = eb;
        return x;
    endfunction

    function automatic out_t mo(logic [31:0] et, logic tm, logic ld, logic [31:0] ea,
                                logic [31:0] bad, logic ds, logic [31:0] npc);
        out_t o;
        o.etype = et; o.tlbmiss = tm; o.load = ld; o.eaddr = ea; o.bad = bad; o.ds = ds;
        o.flush = 1'b1; o.npc = npc; o.redirect = 1'b1;
        return o;
    endfunction

    function automatic bit int_pending(in_t x);
        return x.valid && x.status[0] && !x.status[1] && ((x.cause[15:8] & x.status[15:8]) != 8'h0);
    endfunction

    function automatic bit has_event(in_t x);
        return int_pending(x) || (x.valid && x.flags != 8'h0);
    endfunction

    function automatic out_t ref_commit(in_t x);
        out_t o = mo(32'h0, 1'b0, 1'b0, x.pc, x.bad, x.ds, x.ebase + 32'h180);
        bit found = 1'b0;
        if (int_pending(x)) begin
            o.etype = 32'd1;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (!found && x.flags[ORD[k]]) begin
                    found   = 1'b1;
                    o.etype = CODE[k];
                    if (ORD[k] == 7) begin
                        o.tlbmiss = 1'b1;
                        o.load    = x.tlb_load;
                        if (!x.status[1]) o.npc = x.ebase;
                    end
                    if (ORD[k] == 6) o.npc = x.epc;
                end
            end
        end
        return o;
    endfunction

    task automatic apply(input in_t x);
        @(negedge clk);
        rst = x.rst; valid_i = x.valid; exc_flags_i = x.flags; tlb_load_i = x.tlb_load;
        pc_i = x.pc; in_delay_slot_i = x.ds; badVaddr_i = x.bad; status_i = x.status;
        cause_i = x.cause; epc_i = x.epc; ebase_i = x.ebase;
    endtask

    task automatic chk(input string name, input out_t e);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, e);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    initial begin
        in_t  idle, rst_v, s, b, r;
        out_t exp_cur;
        vec_t tv[$];
        int   busy, nfl, nrd;
        logic [31:0] E, P;

        E = 32'h8000_0000;
        P = 32'hBFC0_0100;
        idle  = '0;
        rst_v = '0;
        rst_v.rst = 1'b1;

        tv.push_back('{"int",      mk(1, 8'h00, 0, 32'h1000, 0, 32'h0, 32'h401, 32'h400, P, E), mo(1, 0, 0, 32'h1000, 32'h0, 0, 32'h8000_0180)});
        tv.push_back('{"tlb_ref",  mk(1, 8'h80, 1, 32'h2000, 0, 32'h0040_1234, 32'h0, 32'h0, P, E), mo(0, 1, 1, 32'h2000, 32'h0040_1234, 0, 32'h8000_0000)});
        tv.push_back('{"eret_sys", mk(1, 8'h44, 0, 32'h3000, 0, 32'h0, 32'h0, 32'h0, P, E), mo(8, 0, 0, 32'h3000, 32'h0, 0, 32'h8000_0180)});
        tv.push_back('{"eret",     mk(1, 8'h40, 0, 32'h3004, 0, 32'h0, 32'h0, 32'h0, P, E), mo(32'he, 0, 0, 32'h3004, 32'h0, 0, P)});
        tv.push_back('{"novalid",  mk(0, 8'h04, 0, 32'h0100, 1, 32'h0, 32'h0, 32'h0, P, E), out_t'('0)});
        tv.push_back('{"dslot",    mk(1, 8'h04, 0, 32'h0100, 1, 32'h0, 32'h0, 32'h0, P, E), mo(8, 0, 0, 32'h0100, 32'h0, 1, 32'h8000_0180)});
        tv.push_back('{"tlb_exl",  mk(1, 8'h80, 0, 32'h4000, 0, 32'h1234, 32'h2, 32'h0, P, E), mo(0, 1, 0, 32'h4000, 32'h1234, 0, 32'h8000_0180)});
        tv.push_back('{"adel",     mk(1, 8'h03, 0, 32'h5000, 0, 32'hDEAD_0001, 32'h0, 32'h0, P, E), mo(4, 0, 0, 32'h5000, 32'hDEAD_0001, 0, 32'h8000_0180)});
        tv.push_back('{"ri",       mk(1, 8'h14, 0, 32'h5004, 0, 32'h0, 32'h0, 32'h0, P, E), mo(32'ha, 0, 0, 32'h5004, 32'h0, 0, 32'h8000_0180)});
        tv.push_back('{"brk",      mk(1, 8'h28, 0, 32'h5008, 0, 32'h0, 32'h0, 32'h0, P, E), mo(9, 0, 0, 32'h5008, 32'h0, 0, 32'h8000_0180)});
        tv.push_back('{"ov",       mk(1, 8'h22, 0, 32'h500c, 0, 32'h0, 32'h0, 32'h0, P, E), mo(32'hc, 0, 0, 32'h500c, 32'h0, 0, 32'h8000_0180)});
        tv.push_back('{"ades",     mk(1, 8'h02, 0, 32'h5010, 0, 32'h77, 32'h0, 32'h0, P, E), mo(5, 0, 0, 32'h5010, 32'h77, 0, 32'h8000_0180)});
        tv.push_back('{"int_win",  mk(1, 8'h81, 1, 32'h6000, 0, 32'h0, 32'h401, 32'h400, P, E), mo(1, 0, 0, 32'h6000, 32'h0, 0, 32'h8000_0180)});
        tv.push_back('{"int_exl",  mk(1, 8'h00, 0, 32'h6004, 0, 32'h0, 32'h403, 32'h400, P, E), out_t'('0)});
        tv.push_back('{"int_im",   mk(1, 8'h00, 0, 32'h6008, 0, 32'h0, 32'h201, 32'h400, P, E), out_t'('0)});
        tv.push_back('{"int_ie0",  mk(1, 8'h00, 0, 32'h600c, 0, 32'h0, 32'h400, 32'h400, P, E), out_t'('0)});
        tv.push_back('{"carry",    mk(1, 8'h01, 0, 32'h7000, 0, 32'h0, 32'h0, 32'h0, P, 32'hFFFF_FF00), mo(4, 0, 0, 32'h7000, 32'h0, 0, 32'h0000_0080)});

        apply(rst_v);
        apply(idle);
        chk("reset", out_t'('0));

        foreach (tv[i]) begin
            apply(rst_v);
            apply(tv[i].inp);
            apply(idle);
            chk(tv[i].name, tv[i].exp);
        end

        // Interrupt commit: flush lasts commit cycle plus FC cycles, one redirect.
        apply(rst_v);
        apply(tv[0].inp);
        nfl = 0; nrd = 0;
        for (int k = 0; k < 8; k++) begin
            apply(idle);
            nfl += int'(flush_o);
            nrd += int'(redirect_o);
        end
        chk_int("flush_len", nfl, FC + 1);
        chk_int("int_redirects", nrd, 1);

        // Break held through commit and flush cycles is dropped.
        s = mk(1, 8'h04, 0, 32'h100, 0, 32'h0, 32'h0, 32'h0, P, E);
        b = mk(1, 8'h08, 0, 32'h104, 0, 32'h0, 32'h0, 32'h0, P, E);
        apply(rst_v);
        apply(s);
        nrd = 0; nfl = 0;
        for (int k = 0; k < 3; k++) begin
            apply(b);
            nrd += int'(redirect_o);
            if (exceptionType_o == 32'h9) nfl++;
        end
        for (int k = 0; k < 5; k++) begin
            apply(idle);
            nrd += int'(redirect_o);
            if (exceptionType_o == 32'h9) nfl++;
        end
        chk_int("brk_dropped_redirects", nrd, 1);
        chk_int("brk_dropped_commits", nfl, 0);

        // Reset in the first flush cycle aborts the sequence.
        apply(rst_v);
        apply(s);
        apply(idle);
        chk("rst_mid_commit", mo(8, 0, 0, 32'h100, 32'h0, 0, 32'h8000_0180));
        apply(rst_v);
        apply(idle);
        chk("rst_mid_abort", out_t'('0));
        nrd = 0; nfl = 0;
        for (int k = 0; k < 4; k++) begin
            apply(idle);
            nrd += int'(redirect_o);
            nfl += int'(flush_o);
        end
        chk_int("rst_mid_no_redirect", nrd, 0);
        chk_int("rst_mid_no_flush", nfl, 0);
        // Back in IDLE: a fresh exception is accepted immediately.
        apply(s);
        apply(idle);
        chk("rst_mid_reaccept", mo(8, 0, 0, 32'h100, 32'h0, 0, 32'h8000_0180));

        // Random run against the reference model.
        apply(rst_v);
        exp_cur = '0;
        busy = 0;
        for (int i = 0; i < 3000; i++) begin
            r.rst      = ($urandom_range(0, 39) == 0);
            r.valid    = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 3))
                0, 1:    r.flags = 8'h00;
                2:       r.flags = 8'h01 << $urandom_range(0, 7);
                default: r.flags = 8'($urandom);
            endcase
            r.tlb_load = 1'($urandom);
            r.pc       = $urandom;
            r.ds       = 1'($urandom);
            r.bad      = $urandom;
            r.status   = {16'h0, 8'($urandom), 6'h0, ($urandom_range(0, 3) == 0), 1'($urandom)};
            r.cause    = ($urandom_range(0, 2) == 0) ? {16'h0, 8'($urandom), 8'h0} : 32'h0;
            r.epc      = $urandom;
            r.ebase    = ($urandom_range(0, 3) == 0) ? $urandom : E;
            apply(r);
            chk($sformatf("rand%0d", i), exp_cur);
            if (r.rst) begin
                exp_cur = '0;
                busy = 0;
            end else if (busy > 0) begin
                busy--;
                exp_cur = '0;
                exp_cur.flush = (busy > 0);
            end else if (has_event(r)) begin
                exp_cur = ref_commit(r);
                busy = 1 + FC;
            end else begin
                exp_cur = '0;
            end
        end
        apply(idle);
        chk("rand_final", exp_cur);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 FLUSH_CYCLES, 2, number of cycles flush_o stays high after the commit cycle (range 0..15).
REQ-003 REFILL_OFF, 32'h0000_0000, vector offset added to ebase for TLB refill with EXL=0.
REQ-004 GENERAL_OFF, 32'h0000_0180, vector offset added to ebase for all other exceptions.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 valid_i  in  1  MEM-stage instruction valid (not a bubble).
REQ-008 exc_flags_i  in  8  MEM-stage flags: [0] adel, [1] ades, [2] syscall, [3] break, [4] reserved instr, [5] overflow, [6] eret, [7] tlbmiss.
REQ-009 tlb_load_i  in  1  TLB miss was on a load/fetch (1) or a store (0).
REQ-010 pc_i  in  32  MEM-stage instruction address.
REQ-011 in_delay_slot_i  in  1  MEM-stage instruction is in a branch delay slot.
REQ-012 badVaddr_i  in  32  faulting data address from MEM.
REQ-013 status_i, cause_i, epc_i, ebase_i  in  32 each  current CP0 register values.
REQ-014 exceptionType_o  out  32  exception code to CP0: 1 int, 4 adel, 5 ades, 8 syscall, 9 break, a RI, c ov, e eret, 0 none.
REQ-015 tlbmiss_o, load_o  out  1 each  TLB miss strobe and its load qualifier to CP0.
REQ-016 exceptionAddr_o, badVaddr_o  out  32 each  address of the committing instruction and faulting address to CP0.
REQ-017 in_delay_slot_o  out  1  delay-slot flag to CP0.
REQ-018 flush_o  out  1  flush all pipeline stages.
REQ-019 newPc_o  out  32  redirect target, valid while redirect_o=1.
REQ-020 redirect_o  out  1  one-cycle PC redirect strobe.

Function
REQ-021 Interrupt pending SHALL be: valid_i & status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]).
REQ-022 States SHALL be IDLE and FLUSH; exceptions are accepted only in IDLE with valid_i=1.
REQ-023 Priority, highest first: interrupt, tlbmiss, adel, RI, syscall, break, overflow, ades, eret; exactly one event commits per acceptance.
REQ-024 On acceptance at edge T, all CP0-facing outputs, flush_o and redirect_o SHALL be registered and valid for exactly cycle T..T+1 (one cycle, latency 1).
REQ-025 tlbmiss commit SHALL drive exceptionType_o=0, tlbmiss_o=1, load_o=tlb_load_i; all others drive tlbmiss_o=0.
REQ-026 exceptionAddr_o=pc_i, in_delay_slot_o=in_delay_slot_i, badVaddr_o=badVaddr_i, captured at acceptance.
REQ-027 newPc_o: eret -> epc_i; tlbmiss with status_i[1]=0 -> ebase_i+REFILL_OFF; otherwise ebase_i+GENERAL_OFF; 32-bit add, carry discarded.
REQ-028 After the commit cycle, state FLUSH SHALL hold flush_o=1 for FLUSH_CYCLES cycles via a 4-bit down-counter, then return to IDLE; FLUSH_CYCLES=0 returns to IDLE directly after commit.
REQ-029 In FLUSH, and in commit cycle, exceptionType_o=0, tlbmiss_o=0, redirect_o=0 except in the commit cycle itself; new flags are ignored, not queued.
REQ-030 valid_i=0 or no flag/interrupt: all strobes 0, state unchanged.
REQ-031 Interrupt pending simultaneous with any flag: interrupt wins; flags are dropped (instruction re-executes after eret).

Reset
REQ-032 With rst=1 at a clk edge: state IDLE, counter 0, all outputs 0, including newPc_o and exceptionType_o.
REQ-033 rst asserted mid-FLUSH SHALL abort the sequence next edge; no further redirect_o.

Verification
REQ-034 status=0x0000_0401, cause=0x0000_0400, ebase=0x8000_0000, valid -> next cycle exceptionType_o=1, newPc_o=0x8000_0180, redirect_o=1, flush_o high 3 cycles total.
REQ-035 flags=0x80, tlb_load_i=1, status[1]=0, ebase=0x8000_0000, badVaddr_i=0x0040_1234 -> tlbmiss_o=1, load_o=1, badVaddr_o=0x0040_1234, newPc_o=0x8000_0000.
REQ-036 flags=0x44 (eret+syscall), epc=0xBFC0_0100 -> exceptionType_o=8, newPc_o=ebase+0x180; flags=0x40 alone -> exceptionType_o=0xe, newPc_o=0xBFC0_0100.
REQ-037 syscall accepted, then break asserted during both FLUSH cycles -> break ignored, exactly one redirect_o pulse.
REQ-038 syscall accepted, rst=1 in first FLUSH cycle -> all outputs 0 next cycle, state IDLE.
REQ-039 flags=0x04, valid_i=0 -> no strobes; in_delay_slot_i=1, pc_i=0x100 with valid -> exceptionAddr_o=0x100, in_delay_slot_o=1.
